dmem_resp: RTL and testbench
============================

// Module: dmem_resp
// PURPOSE
//  Data-memory responder for the EX-stage load/store requests. Accepts one
//  request at a time, holds an internal word-organised RAM, writes byte/half/
//  word stores by lane and returns sign/zero-extended load data after a
//  programmable wait. Asserts a stall to the pipeline while a request is in flight.
// PARAMETERS
//  ADDR_W       32    request address width
//  DEPTH_WORDS  4096  RAM depth in 32-bit words
//  RD_LATENCY   1     extra wait cycles per access, legal range 0..7
// PORTS
//  clk           in   1       single clock, rising edge
//  rst           in   1       synchronous, active-high reset
//  req_valid     in   1       request present
//  req_ready     out  1       responder can accept; 1 only in IDLE
//  req_we        in   1       1 = store, 0 = load
//  req_addr      in   ADDR_W  byte address
//  req_wdata     in   32      store data, right-aligned (byte in [7:0], half in [15:0])
//  req_size      in   2       00 byte, 01 half, 10 word, 11 reserved (treated as error)
//  req_unsigned  in   1       load zero-extend; ignored for word and for stores
//  resp_valid    out  1       one-cycle response pulse
//  resp_rdata    out  32      load result; 0 for stores and errors
//  resp_err      out  1       misaligned / out-of-range / reserved size; valid with resp_valid
//  stall         out  1       pipeline hold
// BEHAVIOUR
//  Reset: state IDLE, cnt 0, resp_valid 0, resp_rdata 0, resp_err 0.
//   RAM contents are not reset.
//  FSM IDLE -> BUSY -> RESP -> IDLE:
//   - IDLE: req_ready = 1.
//   - Accept = req_valid & req_ready. All req_* fields are captured at accept.
//     Later input changes are ignored until the next accept.
//   - IDLE, accept, legal: -> BUSY with cnt = RD_LATENCY.
//   - IDLE, accept, illegal: -> RESP with resp_err = 1 and resp_rdata = 0.
//     No RAM access, no write.
//   - BUSY: if cnt == 0 -> RESP; else cnt decrements.
//     The RAM read/write commits on the BUSY->RESP edge.
//   - RESP: resp_valid = 1 for exactly this cycle -> IDLE.
//     req_ready = 0 in RESP, so no request is accepted here.
//  Latency (accept cycle A):
//   - Legal request: resp_valid in cycle A + RD_LATENCY + 2.
//   - Illegal request: resp_valid in cycle A + 1.
//   - Minimum spacing between legal accepts is RD_LATENCY + 3 cycles.
//  stall = (IDLE & req_valid) | BUSY. stall is 0 in RESP, so the pipeline
//   advances on the response cycle.
//  Illegal request, any of:
//   - size 11;
//   - half with addr[0] = 1;
//   - word with addr[1:0] != 0;
//   - word index addr[ADDR_W-1:2] >= DEPTH_WORDS.
//  Store lanes:
//   - byte: wdata[7:0] -> lane addr[1:0].
//   - half: wdata[15:0] -> lane addr[1] (bits 15:0 or 31:16).
//   - word: all 32 bits.
//   - Unselected lanes are unchanged.
//  Load: extract the same lane; bit 7/15 is sign-extended unless req_unsigned.
//   resp_rdata is held until the next RESP or reset.
//  Reset mid-operation: the pending request is dropped and no response is given.
//   A store that has not reached the BUSY->RESP edge is not written.
//  Width: all address arithmetic is done on ADDR_W bits; there is no wrap.
// TESTING
//  Reset: rst high 2 cycles -> resp_valid = 0, resp_rdata = 0, resp_err = 0,
//   stall = 0, req_ready = 1.
//  Word store/load: SW 0x10 data 0xDEADBEEF, then LW 0x10 -> resp_rdata = 0xDEADBEEF.
//   resp_valid is a single pulse at A + RD_LATENCY + 2; stall is high from A to RESP-1.
//  Byte lanes: SB 0x13 data 0x80, then:
//   - LB 0x13 -> 0xFFFFFF80;
//   - LBU 0x13 -> 0x00000080;
//   - LW 0x10 -> 0x80ADBEEF;
//   - LH 0x12 -> 0xFFFF80AD.
//  Errors:
//   - SH 0x11 -> resp_err = 1 at A + 1; a following LW 0x10 still returns 0x80ADBEEF.
//   - LW at DEPTH_WORDS*4 -> resp_err = 1, resp_rdata = 0.
//  Back-to-back: req_valid held high with 3 loads -> accepts spaced exactly
//   RD_LATENCY + 3 cycles apart; no accept occurs in a RESP cycle.
//  Mid-op reset: SW 0x20 data 0x12345678, rst asserted while in BUSY ->
//   no resp_valid; then LW 0x20 returns the pre-store value.
//   Repeat with RD_LATENCY = 0 and 7.

Source files
------------

// File: rtl/dmem_resp.sv
// dmem_resp: single-outstanding data-memory responder with lane stores, extended loads and a wait counter
// Ports: clk/rst (sync, active-high); i_req_* request (valid, we, addr, wdata, size, unsigned),
//   o_req_ready high only in IDLE; o_resp_valid one-cycle pulse with o_resp_rdata/o_resp_err;
//   o_stall holds the pipeline while a request is pending or in flight.
module dmem_resp #(
   parameter int ADDR_W      = 32,
   parameter int DEPTH_WORDS = 4096,
   parameter int RD_LATENCY  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [31:0]       i_req_wdata,
   input  logic [1:0]        i_req_size,
   input  logic              i_req_unsigned,
   output logic              o_resp_valid,
   output logic [31:0]       o_resp_rdata,
   output logic              o_resp_err,
   output logic              o_stall
);
   localparam int IW = $clog2(DEPTH_WORDS);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t            r_state, w_next;
   logic [2:0]        r_cnt;
   logic              r_we, r_uns, r_err;
   logic [1:0]        r_lo, r_size;
   logic [IW-1:0]     r_idx;
   logic [31:0]       r_wdata, r_rdata;
   logic [31:0]       r_mem [DEPTH_WORDS];
   logic              w_acc, w_ill, w_commit;
   logic [ADDR_W-1:0] w_widx;
   logic [31:0]       w_word, w_sh, w_ld, w_wd;
   logic [3:0]        w_be;
   assign w_acc    = i_req_valid & (r_state == IDLE);
   assign w_widx   = {2'b00, i_req_addr[ADDR_W-1:2]};
   assign w_ill    = (i_req_size == 2'b11) | ((i_req_size == 2'b01) & i_req_addr[0]) |
                     ((i_req_size == 2'b10) & (i_req_addr[1:0] != 2'b00)) |
                     (w_widx >= ADDR_W'(DEPTH_WORDS));
   // the access happens on the last BUSY edge; reset on that edge cancels it
   assign w_commit = (r_state == BUSY) & (r_cnt == 3'd0) & ~rst;
   assign w_word   = r_mem[r_idx];
   // legal alignment makes one shift serve byte, half and word extraction
   assign w_sh     = w_word >> {r_lo, 3'b000};
   assign w_ld     = r_size == 2'b00 ? {{24{~r_uns & w_sh[7]}}, w_sh[7:0]} :
                     r_size == 2'b01 ? {{16{~r_uns & w_sh[15]}}, w_sh[15:0]} : w_sh;
   assign w_wd     = r_size == 2'b10 ? r_wdata : r_size == 2'b01 ? {2{r_wdata[15:0]}} : {4{r_wdata[7:0]}};
   assign w_be     = r_size == 2'b10 ? 4'hf : r_size == 2'b01 ? (r_lo[1] ? 4'b1100 : 4'b0011) : 4'b0001 << r_lo;
   assign o_req_ready  = r_state == IDLE;
   assign o_resp_valid = r_state == RESP;
   assign o_resp_rdata = r_rdata;
   assign o_resp_err   = r_err;
   assign o_stall      = ((r_state == IDLE) & i_req_valid) | (r_state == BUSY);
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_acc ? (w_ill ? RESP : BUSY) : IDLE;
         BUSY:    w_next = r_cnt == 3'd0 ? RESP : BUSY;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 3'd0;
         r_err   <= 1'b0;
         r_rdata <= 32'd0;
      end else begin
         r_state <= w_next;
         if (w_acc) begin
            r_we    <= i_req_we;
            r_lo    <= i_req_addr[1:0];
            r_idx   <= i_req_addr[IW+1:2];
            r_wdata <= i_req_wdata;
            r_size  <= i_req_size;
            r_uns   <= i_req_unsigned;
            r_cnt   <= 3'(RD_LATENCY);
            r_err   <= w_ill;
            if (w_ill) r_rdata <= 32'd0;
         end else if (r_state == BUSY) begin
            if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
            else r_rdata <= r_we ? 32'd0 : w_ld;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (w_commit & r_we)
         for (int b = 0; b < 4; b++)
            if (w_be[b]) r_mem[r_idx][b*8 +: 8] <= w_wd[b*8 +: 8];
   end
endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: scoreboard bench for dmem_resp at RD_LATENCY 1, 0 and 7
module tb_dmem_resp;
   localparam int DEPTH = 4096;
   typedef struct {logic [31:0] d; logic e; int due;} exp_t;
   logic        clk = 0, rst = 1;
   logic [2:0]  v = '0, rdy, rv, er, st;
   logic        we = 0, un = 0;
   logic [31:0] addr = 0, wd = 0;
   logic [1:0]  sz = 0;
   logic [31:0] rd [3];
   int          cyc = 0, n = 0, bad = 0;
   exp_t        q[$];
   exp_t        e;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   for (genvar g = 0; g < 3; g++) begin : g_dut
      dmem_resp #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .RD_LATENCY(g == 0 ? 1 : g == 1 ? 0 : 7)) u_dut (
         .clk(clk), .rst(rst), .i_req_valid(v[g]), .o_req_ready(rdy[g]), .i_req_we(we),
         .i_req_addr(addr), .i_req_wdata(wd), .i_req_size(sz), .i_req_unsigned(un),
         .o_resp_valid(rv[g]), .o_resp_rdata(rd[g]), .o_resp_err(er[g]), .o_stall(st[g]));
   end
   function automatic int lat(int k);
      return k == 0 ? 1 : k == 1 ? 0 : 7;
   endfunction
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
      end
   endtask
   always @(negedge clk)
      if (!rst)
         for (int k = 0; k < 3; k++)
            if (rv[k]) begin
               if (q.size() == 0) chk("unexp_resp", 32'(rv[k]), 0);
               else begin
                  e = q.pop_front();
                  chk("rdata", rd[k], e.d);
                  chk("err", 32'(er[k]), 32'(e.e));
                  chk("resp_cycle", cyc, e.due);
                  chk("stall_in_resp", 32'(st[k]), 0);
                  chk("ready_in_resp", 32'(rdy[k]), 0);
               end
            end
   task automatic drain(int k, bit legal);
      for (int i = 0; i < 40 && q.size() > 0; i++) begin
         if (legal && !rv[k]) chk("stall_busy", 32'(st[k]), 1);
         @(negedge clk); #1;
      end
      chk("resp_timeout", q.size(), 0);
   endtask
   task automatic req(int k, logic w, logic [31:0] a, logic [31:0] d, logic [1:0] s, logic u,
                      logic [31:0] xd, logic xe);
      int  ac;
      bit  got = 0;
      @(posedge clk); #1;
      we = w; addr = a; wd = d; sz = s; un = u; v[k] = 1;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (rdy[k]) begin
            got = 1;
            ac = cyc;
            chk("stall_accept", 32'(st[k]), 1);
         end
      end
      chk("accept_timeout", 32'(got), 1);
      if (got) q.push_back('{xd, xe, ac + (xe ? 1 : lat(k) + 2)});
      @(posedge clk); #1;
      v[k] = 0; we = 1'($urandom); addr = $urandom; wd = $urandom; sz = 2'($urandom); un = 1'($urandom);
      drain(k, !xe);
   endtask
   task automatic b2b(int k);
      int cnt = 0, prev = 0;
      @(posedge clk); #1;
      we = 0; addr = 32'h10; sz = 2'b10; un = 0; v[k] = 1;
      for (int i = 0; i < 200 && cnt < 3; i++) begin
         @(negedge clk);
         if (rdy[k]) begin
            if (cnt > 0) chk("b2b_spacing", cyc - prev, lat(k) + 3);
            prev = cyc;
            cnt++;
            q.push_back('{32'h80ADBEEF, 1'b0, cyc + lat(k) + 2});
         end
      end
      chk("b2b_accepts", cnt, 3);
      @(posedge clk); #1;
      v[k] = 0;
      drain(k, 1'b1);
   endtask
   task automatic mid_reset(int k);
      req(k, 1, 32'h20, 32'h0BADF00D, 2'b10, 0, 32'h0, 0);
      @(posedge clk); #1;
      we = 1; addr = 32'h20; wd = 32'h12345678; sz = 2'b10; v[k] = 1;
      @(negedge clk);
      chk("mr_accept", 32'(rdy[k]), 1);
      @(posedge clk); #1;
      v[k] = 0;
      chk("mr_busy_stall", 32'(st[k]), 1);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      repeat (12) @(posedge clk);
      req(k, 0, 32'h20, 32'h0, 2'b10, 0, 32'h0BADF00D, 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
   initial begin
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_valid", 32'(rv[k]), 0);
         chk("rst_rdata", rd[k], 0);
         chk("rst_err", 32'(er[k]), 0);
         chk("rst_stall", 32'(st[k]), 0);
         chk("rst_ready", 32'(rdy[k]), 1);
      end
      rst = 0;
      for (int k = 0; k < 3; k++) begin
         req(k, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 32'h0, 0);
         req(k, 0, 32'h10, 32'h0, 2'b10, 0, 32'hDEADBEEF, 0);
         req(k, 1, 32'h13, 32'h00000080, 2'b00, 0, 32'h0, 0);
         req(k, 0, 32'h13, 32'h0, 2'b00, 0, 32'hFFFFFF80, 0);
         req(k, 0, 32'h13, 32'h0, 2'b00, 1, 32'h00000080, 0);
         req(k, 0, 32'h10, 32'h0, 2'b10, 0, 32'h80ADBEEF, 0);
         req(k, 0, 32'h12, 32'h0, 2'b01, 0, 32'hFFFF80AD, 0);
         req(k, 0, 32'h12, 32'h0, 2'b01, 1, 32'h000080AD, 0);
         req(k, 1, 32'h11, 32'h0000FFFF, 2'b01, 0, 32'h0, 1);
         req(k, 0, 32'h10, 32'h0, 2'b10, 0, 32'h80ADBEEF, 0);
         req(k, 0, DEPTH * 4, 32'h0, 2'b10, 0, 32'h0, 1);
         req(k, 0, 32'h12, 32'h0, 2'b11, 0, 32'h0, 1);
         req(k, 0, 32'h11, 32'h0, 2'b10, 0, 32'h0, 1);
         b2b(k);
         mid_reset(k);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n, bad);
      $finish;
   end
endmodule
